// File: rtl/lsu_data_mem.sv
// rtl/lsu_data_mem.sv - load/store data memory with valid/ready handshake and wait states
// Byte/half/word access, sign/zero extension, misalignment and range error reporting.
module lsu_data_mem #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_in_idle;
  logic              w_accept;
  logic              w_exec;
  logic              w_ex_we;
  logic [ADDR_W-1:0] w_ex_addr;
  logic [1:0]        w_ex_size;
  logic              w_ex_unsigned;
  logic [31:0]       w_ex_wdata;
  logic [1:0]        w_lane;
  logic [IDX_W-1:0]  w_idx;
  logic              w_oob;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_accept  = w_in_idle & i_req_valid;
  assign w_exec    = (w_accept & (WAIT_CYCLES == 0)) | ((r_state == S_WAIT) & (r_cnt == 4'd0));

  // With no wait states the execute edge is the accept edge, so use the live inputs.
  assign w_ex_we       = w_in_idle ? i_req_we       : r_we;
  assign w_ex_addr     = w_in_idle ? i_req_addr     : r_addr;
  assign w_ex_size     = w_in_idle ? i_req_size     : r_size;
  assign w_ex_unsigned = w_in_idle ? i_req_unsigned : r_unsigned;
  assign w_ex_wdata    = w_in_idle ? i_req_wdata    : r_wdata;

  assign w_lane = w_ex_addr[1:0];
  assign w_idx  = w_ex_addr[IDX_W+1:2];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_oob
      assign w_oob = |w_ex_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  assign w_err = (w_ex_size == 2'b11) |
                 ((w_ex_size == 2'b01) & w_lane[0]) |
                 ((w_ex_size == 2'b10) & (w_lane != 2'b00)) |
                 w_oob;

  always_comb begin
    w_be = 4'b0000;
    w_wd = w_ex_wdata;
    case (w_ex_size)
      2'b00: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{w_ex_wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_ex_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[7:0];
    w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_load = w_word;
    case (w_lane)
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      2'b11:   w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    case (w_ex_size)
      2'b00:   w_load = w_ex_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = w_ex_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP: if (i_rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we       <= i_req_we;
        r_addr     <= i_req_addr;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_wdata    <= i_req_wdata;
        r_cnt      <= WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_exec) begin
        r_err   <= w_err;
        r_rdata <= (w_err | w_ex_we) ? 32'd0 : w_load;
      end else if ((r_state == S_RESP) && i_rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_exec && w_ex_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
      end
    end
  end

  assign o_req_ready = w_in_idle & ~i_reset;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb/tb_lsu_data_mem.sv - randomized self-checking bench for lsu_data_mem
// Instance a has no wait states, instance b has three.
module tb_lsu_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, v_a, we_a, uns_a, rr_a, rdy_a, rv_a, er_a;
  logic [31:0] addr_a, wd_a, rd_a;
  logic [1:0]  sz_a;
  logic        rst_b, v_b, we_b, uns_b, rr_b, rdy_b, rv_b, er_b;
  logic [31:0] addr_b, wd_b, rd_b;
  logic [1:0]  sz_b;

  lsu_data_mem #(.ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_req_valid(v_a), .o_req_ready(rdy_a),
    .i_req_we(we_a), .i_req_addr(addr_a), .i_req_size(sz_a), .i_req_unsigned(uns_a),
    .i_req_wdata(wd_a), .o_rsp_valid(rv_a), .i_rsp_ready(rr_a),
    .o_rsp_rdata(rd_a), .o_rsp_err(er_a)
  );

  lsu_data_mem #(.ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(3)) u_dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_req_valid(v_b), .o_req_ready(rdy_b),
    .i_req_we(we_b), .i_req_addr(addr_b), .i_req_size(sz_b), .i_req_unsigned(uns_b),
    .i_req_wdata(wd_b), .o_rsp_valid(rv_b), .i_rsp_ready(rr_b),
    .o_rsp_rdata(rd_b), .o_rsp_err(er_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [2][256];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int s); return (s == 0) ? rdy_a : rdy_b; endfunction
  function automatic logic get_rv(input int s);  return (s == 0) ? rv_a  : rv_b;  endfunction
  function automatic logic get_er(input int s);  return (s == 0) ? er_a  : er_b;  endfunction
  function automatic logic [31:0] get_rd(input int s); return (s == 0) ? rd_a : rd_b; endfunction

  task automatic drive(input int s, input logic v, input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd);
    if (s == 0) begin
      v_a = v; we_a = we; addr_a = a; sz_a = sz; uns_a = u; wd_a = wd;
    end else begin
      v_b = v; we_b = we; addr_b = a; sz_b = sz; uns_b = u; wd_b = wd;
    end
  endtask

  task automatic set_rr(input int s, input logic x);
    if (s == 0) rr_a = x; else rr_b = x;
  endtask

  task automatic model_clear(input int s);
    for (int i = 0; i < 256; i++) mdl[s][i] = 8'h00;
  endtask

  // Memory as a flat byte array: an access touches 1 << size consecutive bytes.
  task automatic model_txn(input int s, input logic we, input logic [31:0] a, input logic [1:0] sz,
                           input logic u, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n  = 1 << sz;
    er = (sz == 2'd3) || (a % n != 0) || (a >= 32'd256);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < n; k++) mdl[s][a + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mdl[s][a + k]) << (8 * k));
        if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rd = v;
      end
    end
  endtask

  task automatic txn(input int s, input logic we, input logic [31:0] a, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd, input int hold, input string tag,
                     output logic [31:0] rd_o);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    @(negedge clk);
    check_val({tag, ".req_ready"}, 32'(get_rdy(s)), 32'd1);
    drive(s, 1'b1, we, a, sz, u, wd);
    @(posedge clk);
    #1;
    drive(s, 1'b0, 1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom);
    model_txn(s, we, a, sz, u, wd, exp_rd, exp_er);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!get_rv(s) && lat < 50);
    check_val({tag, ".latency"}, 32'(lat), (s == 0) ? 32'd1 : 32'd4);
    check_val({tag, ".rdata"}, get_rd(s), exp_rd);
    check_val({tag, ".err"}, 32'(get_er(s)), 32'(exp_er));
    rd_o = get_rd(s);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_val({tag, ".hold_valid"}, 32'(get_rv(s)), 32'd1);
      check_val({tag, ".hold_rdata"}, get_rd(s), rd_o);
      check_val({tag, ".hold_req_ready"}, 32'(get_rdy(s)), 32'd0);
    end
    set_rr(s, 1'b1);
    @(posedge clk);
    #1;
    set_rr(s, 1'b0);
    @(negedge clk);
    check_val({tag, ".retire_valid"}, 32'(get_rv(s)), 32'd0);
    check_val({tag, ".retire_req_ready"}, 32'(get_rdy(s)), 32'd1);
  endtask

  logic [31:0] r;
  logic [31:0] ra;
  logic [1:0]  rs;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rr_a = 1'b0; rr_b = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    model_clear(0);
    model_clear(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_val("reset.req_ready", 32'(get_rdy(s)), 32'd0);
      check_val("reset.rsp_valid", 32'(get_rv(s)), 32'd0);
      check_val("reset.rdata", get_rd(s), 32'd0);
      check_val("reset.err", 32'(get_er(s)), 32'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0;

    txn(0, 1'b1, 32'h8, 2'd2, 1'b0, 32'h12345678, 0, "sw8", r);
    txn(0, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 0, "lw8", r);
    check_val("lw8.const", r, 32'h12345678);
    txn(0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h0, 0, "sw4", r);
    txn(0, 1'b1, 32'h5, 2'd0, 1'b0, 32'hCDAB, 1, "sb5", r);
    txn(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, "lw4", r);
    check_val("lw4.const", r, 32'h0000AB00);
    txn(0, 1'b0, 32'h5, 2'd0, 1'b0, 32'h0, 0, "lb5", r);
    check_val("lb5.const", r, 32'hFFFFFFAB);
    txn(0, 1'b0, 32'h5, 2'd0, 1'b1, 32'h0, 0, "lbu5", r);
    check_val("lbu5.const", r, 32'h000000AB);
    txn(0, 1'b1, 32'hE, 2'd1, 1'b0, 32'h8001, 0, "she", r);
    txn(0, 1'b0, 32'hE, 2'd1, 1'b0, 32'h0, 0, "lhe", r);
    check_val("lhe.const", r, 32'hFFFF8001);
    txn(0, 1'b0, 32'hE, 2'd1, 1'b1, 32'h0, 0, "lhue", r);
    check_val("lhue.const", r, 32'h00008001);
    txn(0, 1'b0, 32'hC, 2'd2, 1'b0, 32'h0, 0, "lwc", r);
    check_val("lwc.const", r, 32'h80010000);

    txn(0, 1'b0, 32'h2, 2'd2, 1'b0, 32'h0, 0, "err_lw2", r);
    txn(0, 1'b1, 32'h3, 2'd1, 1'b0, 32'hFFFF, 0, "err_sh3", r);
    txn(0, 1'b1, 32'h0, 2'd3, 1'b0, 32'hFFFFFFFF, 0, "err_size3", r);
    txn(0, 1'b1, 32'h100, 2'd2, 1'b0, 32'hFFFFFFFF, 0, "err_sw100", r);
    txn(0, 1'b1, 32'h80000000, 2'd2, 1'b0, 32'hFFFFFFFF, 0, "err_sw_high", r);
    txn(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, "lw0_after_err", r);
    check_val("lw0_after_err.const", r, 32'h0);

    for (int i = 0; i < 80; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      txn(0, 1'($urandom), ra, rs, 1'($urandom), $urandom, $urandom_range(0, 2), "rand_a", r);
    end

    txn(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hAABBCCDD, 5, "b_sw20", r);
    txn(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 5, "b_lw20", r);
    check_val("b_lw20.const", r, 32'hAABBCCDD);
    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      txn(1, 1'($urandom), ra, rs, 1'($urandom), $urandom, $urandom_range(0, 2), "rand_b", r);
    end

    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h8, 2'd2, 1'b0, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    rst_b = 1'b1;
    #1;
    check_val("midrst.rsp_valid", 32'(rv_b), 32'd0);
    check_val("midrst.req_ready", 32'(rdy_b), 32'd0);
    check_val("midrst.rdata", rd_b, 32'd0);
    check_val("midrst.err", 32'(er_b), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    model_clear(1);
    txn(1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 0, "midrst_lw8", r);
    check_val("midrst_lw8.const", r, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
